i2s_tx: RTL and testbench
=========================

Name: i2s_tx

Overview:
- Output end of the effects sample stream: accepts `o_sample`/`o_valid` pulses from `effects_pipeline` and serialises them to an external audio DAC/codec as standard I2S (Philips) frames.
- The stream is mono: the latched sample is sent in both the left and right slots.
- The generator drives the interface: it produces the bit clock and word select from the system clock.
- The input has no backpressure. It is buffered by a one-entry holding register with underrun and overrun flags.

Parameters:
- `fxp_size`, 16, sample width in bits (two's complement).
- `clk_div`, 4, system clocks per bit-clock half period (≥1).
- `frame_bits`, 32, bit-clock periods per channel slot (must be ≥ `fxp_size` + 1).

Ports:
- `clk`, in, 1, system clock.
- `rst`, in, 1, asynchronous active-high reset.
- `i_valid`, in, 1, one-cycle strobe: `i_sample` holds a new sample.
- `i_sample`, in, `fxp_size`, sample from the effects pipeline.
- `o_bclk`, out, 1, I2S bit clock.
- `o_lrclk`, out, 1, word select: 0 = left slot, 1 = right slot.
- `o_sdata`, out, 1, serial data, MSB first.
- `o_frame_start`, out, 1, one-cycle pulse when a new frame sample is loaded.
- `o_underrun`, out, 1, one-cycle pulse: frame load with no fresh sample since the previous load.
- `o_overrun`, out, 1, one-cycle pulse: `i_valid` arrived while the holding register was still fresh.

Behaviour:
- Reset (async, immediate): `o_bclk`=0, `o_lrclk`=0, `o_sdata`=0, `o_frame_start`=`o_underrun`=`o_overrun`=0.
  - Holding register=0, frame register=0, fresh=0, `div_cnt`=0, `bit_cnt`=2*`frame_bits`-1.
- Clock divider:
  - `div_cnt` increments every clk. At `clk_div`-1 it wraps to 0 and `o_bclk` toggles.
  - A "fall event" is the cycle `o_bclk` goes 1→0. The first fall event is at the 2*`clk_div`-th clk edge after `rst` deasserts.
- Bit counter: on each fall event `bit_cnt` increments modulo 2*`frame_bits`.
  - `o_lrclk` = (`bit_cnt` ≥ `frame_bits`), registered so it changes on the fall event.
  - Slot position p = `bit_cnt` mod `frame_bits`.
- Data timing (one-bit I2S delay): `o_sdata` is updated on fall events only.
  - p=0: `o_sdata` = 0.
  - p=1..`fxp_size`: `o_sdata` = frame_reg[`fxp_size`-p], i.e. MSB at p=1.
  - p>`fxp_size`: `o_sdata` = 0.
  - Data is therefore stable at every `o_bclk` rising edge.
- Frame load (fall event where `bit_cnt` wraps to 0):
  - frame_reg ← holding; `o_frame_start` pulses.
  - If fresh=0, `o_underrun` pulses and the previous frame_reg value is repeated (holding is unchanged).
  - fresh ← 0.
  - The right slot re-sends the same frame_reg.
- Input capture: on `i_valid`, holding ← `i_sample` and fresh ← 1. If fresh was already 1 (and this is not a load cycle), `o_overrun` pulses; the last sample wins.
- `i_valid` on a frame-load cycle: bypass.
  - frame_reg ← `i_sample`, fresh ← 0.
  - No underrun and no overrun.
- Sample rate = f_clk / (4·`clk_div`·`frame_bits`). Defaults at 50 MHz: 97.66 kHz.
- Latency from `i_valid` to the MSB on the wire: up to one frame plus 1 bit-clock period. No guaranteed alignment to the pipeline.
- Reset mid-frame: the line drops to idle immediately (bclk/lrclk/sdata = 0). The frame in progress is discarded.
  - After release, the first frame is 0x0000 with `o_underrun` pulsed, unless `i_valid` precedes or coincides with that load.

Test Plan (`clk_div`=2, `frame_bits`=20, `fxp_size`=16; bclk period 4 clk, frame 160 clk):
- Release `rst`, no `i_valid` → first `o_bclk` fall at clk edge 4; `o_frame_start` and `o_underrun` pulse there. `o_sdata` stays 0 for the whole frame; `o_lrclk` rises on the 20th fall event after the load.
- `i_valid` with `i_sample`=16'hA5C3 mid-frame → at the next load, the left slot reads 0,1010010111000011,000; the right slot (`o_lrclk`=1) is identical; no underrun; bits stable on every `o_bclk` rise.
- After the A5C3 frame, no further `i_valid` → next load pulses `o_underrun` and re-sends A5C3 in both slots.
- `i_valid` 16'h1234, then `i_valid` 16'h8001 before the next load → `o_overrun` pulses on the second strobe; the next frame carries 8001.
- `i_valid` 16'h7FFF on exactly the load cycle → that frame carries 7FFF; `o_underrun`=0 and `o_overrun`=0; a load 160 clk later pulses underrun and repeats 7FFF.
- Assert `rst` for 3 clk while `o_lrclk`=1 mid-slot → all outputs 0 within the assert cycle; after release, behaviour matches the first scenario (first frame 0x0000, underrun pulse).

Source files
------------

// File: rtl/i2s_tx.sv
// ---------------------------------------------------------------------------
// i2s_tx
//
// Purpose:
//   Serialises the mono sample stream coming out of the effects pipeline onto
//   a standard I2S (Philips) link towards an external DAC/codec. The block is
//   the interface master: it derives the bit clock and word select from the
//   system clock. The latched sample is sent in both the left and the right
//   slot. The input has no backpressure, so a one-entry holding register sits
//   between the pipeline strobe and the frame register. Underrun and overrun
//   are reported as one-cycle pulses.
//
// Parameters:
//   fxp_size   - sample width in bits (two's complement)
//   clk_div    - system clocks per bit-clock half period (>= 1)
//   frame_bits - bit-clock periods per channel slot (>= fxp_size + 1)
//
// Ports:
//   clk           in   system clock
//   rst           in   asynchronous active-high reset
//   i_valid       in   one-cycle strobe, i_sample holds a new sample
//   i_sample      in   sample from the effects pipeline
//   o_bclk        out  I2S bit clock
//   o_lrclk       out  word select, 0 = left slot, 1 = right slot
//   o_sdata       out  serial data, MSB first, one-bit I2S delay
//   o_frame_start out  one-cycle pulse when a new frame sample is loaded
//   o_underrun    out  one-cycle pulse, frame load without a fresh sample
//   o_overrun     out  one-cycle pulse, i_valid while holding was still fresh
// ---------------------------------------------------------------------------
module i2s_tx #(
  parameter int fxp_size   = 16,
  parameter int clk_div    = 4,
  parameter int frame_bits = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_valid,
  input  logic [fxp_size-1:0] i_sample,
  output logic                o_bclk,
  output logic                o_lrclk,
  output logic                o_sdata,
  output logic                o_frame_start,
  output logic                o_underrun,
  output logic                o_overrun
);

  // A divider of 1 still needs a one-bit counter that simply stays at zero.
  localparam int DIV_W = (clk_div > 1) ? $clog2(clk_div) : 1;
  localparam int BIT_W = $clog2(2 * frame_bits);

  localparam logic [DIV_W-1:0] DIV_LAST     = DIV_W'(clk_div - 1);
  localparam logic [DIV_W-1:0] DIV_ONE      = DIV_W'(1);
  localparam logic [BIT_W-1:0] BIT_LAST     = BIT_W'(2 * frame_bits - 1);
  localparam logic [BIT_W-1:0] BIT_ONE      = BIT_W'(1);
  localparam logic [BIT_W-1:0] FRAME_BITS_C = BIT_W'(frame_bits);

  // Clock generation state
  logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
  logic                bclk_q, bclk_d;
  logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic                lrclk_q, lrclk_d;
  logic                sdata_q, sdata_d;

  // Sample buffering state
  logic [fxp_size-1:0] hold_q, hold_d;
  logic [fxp_size-1:0] frame_q, frame_d;
  logic                fresh_q, fresh_d;

  // Registered status pulses
  logic                frame_start_q, frame_start_d;
  logic                underrun_q, underrun_d;
  logic                overrun_q, overrun_d;

  // Internal decode
  logic                div_wrap;
  logic                fall_evt;
  logic                load_evt;
  logic [BIT_W-1:0]    bit_cnt_next;
  logic [BIT_W-1:0]    slot_pos;
  logic                serial_bit;

  // Bit-clock divider and event decode. A fall event is the divider wrap
  // that takes bclk from 1 to 0; every other piece of state in the block
  // only moves on that cycle, so sdata and lrclk change while bclk is low and
  // are stable at the following rising edge. The frame load is the fall
  // event on which the bit counter wraps back to slot position 0.
  always_comb begin
    div_wrap     = (div_cnt_q == DIV_LAST);
    fall_evt     = div_wrap && bclk_q;
    div_cnt_d    = div_wrap ? '0 : (div_cnt_q + DIV_ONE);
    bclk_d       = div_wrap ? ~bclk_q : bclk_q;
    bit_cnt_next = (bit_cnt_q == BIT_LAST) ? '0 : (bit_cnt_q + BIT_ONE);
    load_evt     = fall_evt && (bit_cnt_q == BIT_LAST);
    bit_cnt_d    = fall_evt ? bit_cnt_next : bit_cnt_q;
  end

  // Serial data selection for the bit that starts on this fall event.
  // Position 0 of each slot is the one-bit I2S delay, positions 1..fxp_size
  // carry the sample MSB first, and the tail of the slot is zero padded.
  // The loop form avoids a subtracted variable index into the frame.
  always_comb begin
    slot_pos   = (bit_cnt_next >= FRAME_BITS_C) ? (bit_cnt_next - FRAME_BITS_C)
                                                : bit_cnt_next;
    serial_bit = 1'b0;
    for (int i = 0; i < fxp_size; i++) begin
      if (slot_pos == BIT_W'(fxp_size - i)) begin
        serial_bit = frame_q[i];
      end
    end
  end

  // Output line registers: word select reflects which half of the frame the
  // next bit belongs to, data is the bit picked above.
  always_comb begin
    lrclk_d = lrclk_q;
    sdata_d = sdata_q;
    if (fall_evt) begin
      lrclk_d = (bit_cnt_next >= FRAME_BITS_C);
      sdata_d = serial_bit;
    end
  end

  // Holding register and frame load.
  // On a load the frame takes the held sample if one arrived since the last
  // load; otherwise the old frame is sent again and an underrun is flagged.
  // A strobe that lands exactly on the load cycle goes straight into the
  // frame, which counts as neither underrun nor overrun and leaves nothing
  // fresh behind. Away from a load, a strobe overwrites the holding register
  // and flags an overrun if the previous sample was never consumed.
  always_comb begin
    hold_d        = hold_q;
    frame_d       = frame_q;
    fresh_d       = fresh_q;
    frame_start_d = load_evt;
    underrun_d    = 1'b0;
    overrun_d     = 1'b0;
    if (load_evt) begin
      fresh_d = 1'b0;
      if (i_valid) begin
        frame_d = i_sample;
      end else if (fresh_q) begin
        frame_d = hold_q;
      end else begin
        underrun_d = 1'b1;
      end
    end else if (i_valid) begin
      hold_d    = i_sample;
      fresh_d   = 1'b1;
      overrun_d = fresh_q;
    end
  end

  // State register. Reset drops the line to idle at once and parks the bit
  // counter on the last position, so the first fall event after release is
  // a frame load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_q     <= '0;
      bclk_q        <= 1'b0;
      bit_cnt_q     <= BIT_LAST;
      lrclk_q       <= 1'b0;
      sdata_q       <= 1'b0;
      hold_q        <= '0;
      frame_q       <= '0;
      fresh_q       <= 1'b0;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      div_cnt_q     <= div_cnt_d;
      bclk_q        <= bclk_d;
      bit_cnt_q     <= bit_cnt_d;
      lrclk_q       <= lrclk_d;
      sdata_q       <= sdata_d;
      hold_q        <= hold_d;
      frame_q       <= frame_d;
      fresh_q       <= fresh_d;
      frame_start_q <= frame_start_d;
      underrun_q    <= underrun_d;
      overrun_q     <= overrun_d;
    end
  end

  assign o_bclk        = bclk_q;
  assign o_lrclk       = lrclk_q;
  assign o_sdata       = sdata_q;
  assign o_frame_start = frame_start_q;
  assign o_underrun    = underrun_q;
  assign o_overrun     = overrun_q;

endmodule

// File: tb/tb_i2s_tx.sv
// ---------------------------------------------------------------------------
// tb_i2s_tx
//
// Purpose:
//   Directed bench for i2s_tx with clk_div=2, frame_bits=20, fxp_size=16.
//   A reference model tracks the holding/frame registers from the bench's
//   own cycle count and pushes each loaded frame sample into a queue; a
//   monitor deserialises the line on every bit-clock rise and pops the
//   queue when a full frame has been collected.
// ---------------------------------------------------------------------------
module tb_i2s_tx;

  localparam int FXP        = 16;
  localparam int CDIV       = 2;
  localparam int FBITS      = 20;
  localparam int FIRST_FALL = 2 * CDIV;
  localparam int FRAME_CLKS = 4 * CDIV * FBITS;
  localparam int PAD        = FBITS - FXP - 1;
  localparam int WAIT_LIMIT = 3000;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           i_valid = 1'b0;
  logic [FXP-1:0] i_sample = '0;
  logic           o_bclk;
  logic           o_lrclk;
  logic           o_sdata;
  logic           o_frame_start;
  logic           o_underrun;
  logic           o_overrun;

  int assertCount = 0;
  int failCount = 0;
  int framesChecked = 0;

  // Model state, advanced on each rising clock edge
  int             cyc = 0;
  logic [FXP-1:0] mHold = '0;
  logic [FXP-1:0] mFrame = '0;
  logic           mFresh = 1'b0;
  logic           expLoad = 1'b0;
  logic           expUnder = 1'b0;
  logic           expOver = 1'b0;
  logic [FXP-1:0] frameQ[$];

  // Monitor state
  int              bitIdx = -1;
  logic            prevBclk = 1'b0;
  logic [2*FBITS-1:0] dataSh = '0;
  logic [2*FBITS-1:0] lrSh = '0;
  logic [FXP-1:0]  expWord;

  i2s_tx #(
    .fxp_size  (FXP),
    .clk_div   (CDIV),
    .frame_bits(FBITS)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_valid      (i_valid),
    .i_sample     (i_sample),
    .o_bclk       (o_bclk),
    .o_lrclk      (o_lrclk),
    .o_sdata      (o_sdata),
    .o_frame_start(o_frame_start),
    .o_underrun   (o_underrun),
    .o_overrun    (o_overrun)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    assertCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Drive one strobe at the current falling edge; the DUT samples it on the
  // next rising edge.
  task automatic applyStimulus(input logic [FXP-1:0] sample);
    i_valid  = 1'b1;
    i_sample = sample;
    @(negedge clk);
    i_valid  = 1'b0;
  endtask

  // Step falling edges until the model cycle count reaches target.
  task automatic waitCycle(input int target);
    int guard;
    guard = 0;
    while (cyc != target && guard < WAIT_LIMIT) begin
      @(negedge clk);
      guard++;
    end
    if (cyc != target) begin
      checkOutput("wait_timeout", 64'(cyc), 64'(target));
    end
  endtask

  // Reference model: the frame load falls on a fixed cycle grid counted
  // from reset release, and the holding/fresh bookkeeping follows it.
  always @(posedge clk) begin
    if (rst) begin
      cyc      = 0;
      mHold    = '0;
      mFrame   = '0;
      mFresh   = 1'b0;
      expLoad  = 1'b0;
      expUnder = 1'b0;
      expOver  = 1'b0;
    end else begin
      cyc++;
      expLoad  = (cyc >= FIRST_FALL) && (((cyc - FIRST_FALL) % FRAME_CLKS) == 0);
      expUnder = 1'b0;
      expOver  = 1'b0;
      if (expLoad) begin
        if (i_valid) begin
          mFrame = i_sample;
        end else if (mFresh) begin
          mFrame = mHold;
        end else begin
          expUnder = 1'b1;
        end
        mFresh = 1'b0;
        frameQ.push_back(mFrame);
      end else if (i_valid) begin
        expOver = mFresh;
        mHold   = i_sample;
        mFresh  = 1'b1;
      end
    end
  end

  // Monitor: pulse checks every cycle, line capture on each bclk rise.
  always @(negedge clk) begin
    if (rst) begin
      bitIdx   = -1;
      prevBclk = 1'b0;
      frameQ.delete();
    end else begin
      checkOutput("frame_start", 64'(o_frame_start), 64'(expLoad));
      checkOutput("underrun", 64'(o_underrun), 64'(expUnder));
      checkOutput("overrun", 64'(o_overrun), 64'(expOver));
      if (expLoad) begin
        bitIdx = 0;
      end
      if (o_bclk && !prevBclk && bitIdx >= 0) begin
        dataSh = {dataSh[2*FBITS-2:0], o_sdata};
        lrSh   = {lrSh[2*FBITS-2:0], o_lrclk};
        bitIdx++;
        if (bitIdx == 2 * FBITS) begin
          bitIdx = -1;
          if (frameQ.size() == 0) begin
            checkOutput("frame_queue_empty", 64'(frameQ.size()), 64'd1);
          end else begin
            expWord = frameQ.pop_front();
            framesChecked++;
            checkOutput("frame_data", 64'(dataSh),
                        64'({1'b0, expWord, {PAD{1'b0}}, 1'b0, expWord, {PAD{1'b0}}}));
            checkOutput("frame_lrclk", 64'(lrSh), 64'({{FBITS{1'b0}}, {FBITS{1'b1}}}));
          end
        end
      end
      prevBclk = o_bclk;
    end
  end

  // Directed sequence
  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset_outputs",
                64'({o_bclk, o_lrclk, o_sdata, o_frame_start, o_underrun, o_overrun}),
                64'd0);
    rst = 1'b0;

    // First fall event lands on clock edge 2*clk_div after release
    waitCycle(FIRST_FALL - 1);
    checkOutput("bclk_before_first_fall", 64'(o_bclk), 64'd1);
    waitCycle(FIRST_FALL);
    checkOutput("bclk_first_fall", 64'(o_bclk), 64'd0);

    // Mid-frame sample, then an underrun repeat of it
    waitCycle(50);
    applyStimulus(16'hA5C3);

    // Two strobes inside one frame: overrun, last sample wins
    waitCycle(350);
    applyStimulus(16'h1234);
    waitCycle(400);
    applyStimulus(16'h8001);

    // Strobe exactly on the load cycle (edge 644) bypasses into the frame
    waitCycle(FIRST_FALL + 4 * FRAME_CLKS - 1);
    applyStimulus(16'h7FFF);

    // Reset mid right slot
    waitCycle(FIRST_FALL + 5 * FRAME_CLKS + 100);
    checkOutput("lrclk_before_reset", 64'(o_lrclk), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_reset_line",
                64'({o_bclk, o_lrclk, o_sdata, o_frame_start, o_underrun, o_overrun}),
                64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Two more frames of 0x0000 with underrun after release
    waitCycle(FIRST_FALL + 2 * FRAME_CLKS - 1);
    checkOutput("queue_drained", 64'(frameQ.size()), 64'd0);
    checkOutput("frames_seen", 64'(framesChecked), 64'd7);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

  // Watchdog so the run always terminates
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
